// File: rtl/dh_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for g^x mod p.
// Every reduction is delegated to an external reducer over a req/ack handshake.
module dh_modexp_ctrl #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   g,
  input  logic [EXP_W-1:0]   x,
  input  logic [WIDTH-1:0]   p,
  output logic               red_req,
  output logic [2*WIDTH-1:0] red_op,
  output logic [WIDTH-1:0]   red_mod,
  input  logic               red_ack,
  input  logic [WIDTH-1:0]   red_res,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               err
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, PRE, SQR, MUL, STEP, FIN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   g_q, p_q, acc, base;
  logic [EXP_W-1:0]   x_q;
  logic [IDX_W-1:0]   idx;
  logic [2*WIDTH-1:0] acc_ext, base_ext, sq_prod, mul_prod;
  logic               xfer;
  logic               trivial;

  assign red_mod  = p_q;
  assign xfer     = red_req & red_ack;
  assign trivial  = (p_q == '0) || (p_q == WIDTH'(1)) || (x_q == '0);
  assign acc_ext  = {{WIDTH{1'b0}}, acc};
  assign base_ext = {{WIDTH{1'b0}}, base};
  assign sq_prod  = acc_ext * acc_ext;
  assign mul_prod = acc_ext * base_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = trivial ? FIN : PRE;
      PRE:     if (xfer) state_nxt = SQR;
      SQR:     if (xfer) state_nxt = x_q[idx] ? MUL : STEP;
      MUL:     if (xfer) state_nxt = STEP;
      STEP:    state_nxt = (idx == '0) ? FIN : SQR;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // red_req drops for one cycle after each completion; STEP or the next
  // issue state re-raises it so back-to-back transactions cost two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q     <= '0;
      x_q     <= '0;
      p_q     <= '0;
      acc     <= '0;
      base    <= '0;
      idx     <= '0;
      red_req <= 1'b0;
      red_op  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            g_q  <= g;
            x_q  <= x;
            p_q  <= p;
            err  <= 1'b0;
            busy <= 1'b1;
          end
        end
        CHECK: begin
          if (p_q == '0) begin
            result <= '0;
            err    <= 1'b1;
          end else if (p_q == WIDTH'(1)) begin
            result <= '0;
          end else if (x_q == '0) begin
            result <= WIDTH'(1);
          end else begin
            acc     <= WIDTH'(1);
            idx     <= IDX_W'(EXP_W - 1);
            red_req <= 1'b1;
            red_op  <= {{WIDTH{1'b0}}, g_q};
          end
        end
        PRE: begin
          if (xfer) begin
            base    <= red_res;
            red_req <= 1'b0;
          end
        end
        SQR: begin
          if (xfer) begin
            acc     <= red_res;
            red_req <= 1'b0;
          end else if (!red_req) begin
            red_req <= 1'b1;
            red_op  <= sq_prod;
          end
        end
        MUL: begin
          if (xfer) begin
            acc     <= red_res;
            red_req <= 1'b0;
          end else if (!red_req) begin
            red_req <= 1'b1;
            red_op  <= mul_prod;
          end
        end
        STEP: begin
          if (idx == '0) begin
            result <= acc;
          end else begin
            idx     <= idx - 1'b1;
            red_req <= 1'b1;
            red_op  <= sq_prod;
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dh_modexp_ctrl.md
Name: dh_modexp_ctrl

Overview:
Sequencer that computes R = g^x mod p for the Diffie-Hellman key exchange using left-to-right binary square-and-multiply. It does no reduction itself. Every modular reduction of a 64-bit operand is issued over a req/ack handshake to an external reduction unit that computes operand mod p. The block sits between the key-exchange top level, which supplies g, x and p and consumes R, and the shared reduction datapath.

Parameters:
WIDTH, 32, bit width of g, p, result and reduction remainder
EXP_W, 32, bit width of exponent x; equals the number of square steps per operation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin; sampled only in IDLE
g  in  WIDTH  base, latched on accepted start
x  in  EXP_W  exponent, latched on accepted start
p  in  WIDTH  modulus, latched on accepted start
red_req  out  1  reduction request
red_op  out  2*WIDTH  operand to reduce
red_mod  out  WIDTH  modulus for reducer; always the latched p
red_ack  in  1  reducer completion
red_res  in  WIDTH  red_op mod red_mod; valid while red_ack=1
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle completion pulse
result  out  WIDTH  g^x mod p; held until next accepted start
err  out  1  set with done when p==0; cleared on next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. red_req, red_op, busy, done, result, err, accumulator, base register and bit index all 0. Reset mid-operation aborts the operation with no done pulse.
- States and transitions:
  - IDLE: start=1 latches g, x and p, clears err, sets busy, goes to CHECK. start while not IDLE is ignored.
  - CHECK: p==0 -> result=0, err=1, go to FIN. p==1 -> result=0, go to FIN. x==0 -> result=1, go to FIN. Otherwise acc=1, idx=EXP_W-1, go to PRE.
  - PRE: issue red_op = zero-extended g; on completion base = red_res, go to SQR.
  - SQR: issue red_op = acc*acc (full 2*WIDTH product); on completion acc = red_res. If x[idx]=1 go to MUL; else go to STEP.
  - MUL: issue red_op = acc*base; on completion acc = red_res, go to STEP.
  - STEP: idx==0 -> result = acc, go to FIN. Otherwise idx decrements, go to SQR.
  - FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- Handshake rules:
  - In an issue state, red_req=1 and red_op/red_mod are held stable.
  - A transaction completes at the first rising edge where red_req=1 and red_ack=1; red_res is captured at that edge.
  - red_req is 0 in the cycle after completion, so there is at least one idle cycle between transactions.
  - red_ack seen while red_req=0 is ignored. The reducer may ack in the same cycle req rises or any number of cycles later.
- Transaction count: the reducer sees exactly 1 + EXP_W + popcount(x) transactions for p>=2, x!=0; zero transactions otherwise.
- Latency: with ack in the same cycle as req, latency is 2 + 2*(1+EXP_W+popcount(x)) + 1 cycles from accepted start to done. It grows one cycle per ack wait cycle.
- Widths: acc and base are always < p, so products fit in 2*WIDTH bits with no overflow. result is always < p when err=0.
- Timing of done: result and err are valid in the same cycle done=1.
- Back-to-back operation: start asserted in the cycle after done is accepted.

Test Plan:
- g=5, x=6, p=23, EXP_W=32, immediate ack -> result=8, err=0, done pulse width 1, exactly 35 reducer transactions.
- g=2, x=10, p=1000, random ack delay 0..5 cycles -> result=24; red_op stable and red_req high throughout every wait.
- Edge values: g=7, x=0, p=23 -> result=1; g=7, x=9, p=1 -> result=0; p=0 -> result=0, err=1. None of these issue any red_req; done arrives 3 cycles after start.
- start pulsed while busy with g=3, x=4, p=11 -> ignored; original operation (g=5, x=6, p=23) completes with result=8.
- rst asserted mid-SQR with red_req high -> all outputs 0 asynchronously, no done pulse. A fresh start with g=2, x=10, p=1000 then gives 24.
- 200 random (g, x, p>=2) vectors with random ack latency -> result matches reference model; busy/done sequencing holds for every vector.
